// File: rtl/memoria_escritura.sv
// memoria_escritura
//   Captures a stream of DATA_W-bit words into a DEPTH-entry memory under a
//   valid/ready handshake, then freezes the image for random-access readback
//   through a one-cycle registered read port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (control and valor only)
//   inicio     start-capture pulse; restarts capture at address 0
//   dato_in    write data
//   valido_in  write data valid
//   listo_out  ready: high only while capturing
//   lleno      all DEPTH entries written since the last inicio
//   conteo     words accepted since the last inicio (0..DEPTH)
//   dir_lect   readback address
//   valor      registered readback data (read-before-write)
module memoria_escritura #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  input  logic [DATA_W-1:0] dato_in,
  input  logic              valido_in,
  output logic              listo_out,
  output logic              lleno,
  output logic [ADDR_W:0]   conteo,
  input  logic [ADDR_W-1:0] dir_lect,
  output logic [DATA_W-1:0] valor
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CAPTURA = 2'd1,
    LLENO   = 2'd2
  } estado_t;

  estado_t             estado;
  logic [ADDR_W-1:0]   puntero;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                acepta;

  localparam logic [ADDR_W:0]   CONTEO_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ULTIMA_DIR = ADDR_W'(DEPTH - 1);

  // Increment that holds at DEPTH; capture stops at the last entry, so the
  // clamp only guards against an impossible wrap.
  function automatic logic [ADDR_W:0] conteo_sat(input logic [ADDR_W:0] c);
    if (c >= CONTEO_MAX) return CONTEO_MAX;
    return c + 1'b1;
  endfunction

  // Ready comes from registered state only, never from valido_in/inicio.
  assign listo_out = (estado == CAPTURA);

  // inicio outranks a coincident word, which is then discarded.
  assign acepta = valido_in & listo_out & ~inicio;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= REPOSO;
      puntero <= '0;
      conteo  <= '0;
      lleno   <= 1'b0;
    end else if (inicio) begin
      estado  <= CAPTURA;
      puntero <= '0;
      conteo  <= '0;
      lleno   <= 1'b0;
    end else if (acepta) begin
      puntero <= puntero + 1'b1;
      conteo  <= conteo_sat(conteo);
      if (puntero == ULTIMA_DIR) begin
        estado <= LLENO;
        lleno  <= 1'b1;
      end
    end
  end

  // Memory is deliberately not reset so the captured image survives rst.
  always_ff @(posedge clk) begin
    if (!rst && acepta) mem[puntero] <= dato_in;
  end

  // Registered readback; nonblocking semantics give read-before-write.
  always_ff @(posedge clk) begin
    if (rst) valor <= '0;
    else     valor <= mem[dir_lect];
  end

endmodule

// File: tb/tb_memoria_escritura.sv
module tb_memoria_escritura;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inicio = 1'b0;
  logic [DATA_W-1:0] dato_in = '0;
  logic              valido_in = 1'b0;
  logic              listo_out;
  logic              lleno;
  logic [ADDR_W:0]   conteo;
  logic [ADDR_W-1:0] dir_lect = '0;
  logic [DATA_W-1:0] valor;

  int n_chk = 0;
  int n_fail = 0;

  memoria_escritura #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .dato_in(dato_in),
    .valido_in(valido_in), .listo_out(listo_out), .lleno(lleno),
    .conteo(conteo), .dir_lect(dir_lect), .valor(valor)
  );

  always #5 clk = ~clk;

  // Behavioural model: a capture session is "number of words taken so far";
  // word k goes to entry k, the session ends when k reaches DEPTH.
  bit          capturing = 0;
  bit          full = 0;
  int          taken = 0;
  logic [7:0]  img [DEPTH];
  bit          known [DEPTH];
  logic [7:0]  read_exp = 8'h00;
  bit          read_known = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      capturing = 0; full = 0; taken = 0;
      read_exp = 8'h00; read_known = 1;
    end else begin
      read_exp   = img[dir_lect];
      read_known = known[dir_lect];
      if (inicio) begin
        capturing = 1; full = 0; taken = 0;
      end else if (capturing && valido_in) begin
        img[taken] = dato_in;
        known[taken] = 1;
        taken = taken + 1;
        if (taken == DEPTH) begin
          capturing = 0; full = 1;
        end
      end
    end
    chk_en = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_listo", 32'(listo_out), 32'(capturing));
      chk("model_lleno", 32'(lleno), 32'(full));
      chk("model_conteo", 32'(conteo), 32'(taken));
      if (read_known) chk("model_valor", 32'(valor), 32'(read_exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    valido_in = 1'b1; dato_in = d;
    tick();
    valido_in = 1'b0;
  endtask

  task automatic start();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  initial begin
    // Reset defaults
    tick(); tick();
    rst = 1'b0;
    chk("rst_listo", 32'(listo_out), 0);
    chk("rst_lleno", 32'(lleno), 0);
    chk("rst_conteo", 32'(conteo), 0);
    chk("rst_valor", 32'(valor), 0);
    valido_in = 1'b1; dato_in = 8'h99;
    tick(); tick();
    valido_in = 1'b0;
    chk("idle_ignore_conteo", 32'(conteo), 0);

    // Back-to-back fill
    start();
    chk("start_listo", 32'(listo_out), 1);
    put(8'hA1); chk("b2b_conteo1", 32'(conteo), 1);
    put(8'hB2); chk("b2b_conteo2", 32'(conteo), 2);
    put(8'hC3); chk("b2b_conteo3", 32'(conteo), 3);
    put(8'hD4); chk("b2b_conteo4", 32'(conteo), 4);
    chk("b2b_lleno", 32'(lleno), 1);
    chk("b2b_listo", 32'(listo_out), 0);
    dir_lect = 2'd0; tick(); chk("b2b_rd0", 32'(valor), 32'h A1);
    dir_lect = 2'd1; tick(); chk("b2b_rd1", 32'(valor), 32'h B2);
    dir_lect = 2'd2; tick(); chk("b2b_rd2", 32'(valor), 32'h C3);
    dir_lect = 2'd3; tick(); chk("b2b_rd3", 32'(valor), 32'h D4);

    // Gapped writes
    start();
    for (int i = 1; i <= 4; i++) begin
      put(8'(i));
      if (i < 4) chk("gap_lleno_low", 32'(lleno), 0);
      else       chk("gap_lleno_high", 32'(lleno), 1);
      tick();
    end
    put(8'hFF);
    chk("gap_full_conteo", 32'(conteo), 4);
    dir_lect = 2'd0; tick(); chk("gap_rd0", 32'(valor), 32'h01);
    dir_lect = 2'd3; tick(); chk("gap_rd3", 32'(valor), 32'h04);

    // Restart collision
    start();
    put(8'h10); put(8'h20);
    chk("coll_conteo2", 32'(conteo), 2);
    inicio = 1'b1; valido_in = 1'b1; dato_in = 8'h77;
    tick();
    inicio = 1'b0; valido_in = 1'b0;
    chk("coll_conteo0", 32'(conteo), 0);
    chk("coll_listo", 32'(listo_out), 1);
    put(8'h55);
    chk("coll_conteo1", 32'(conteo), 1);
    dir_lect = 2'd0; tick(); chk("coll_rd0", 32'(valor), 32'h55);
    dir_lect = 2'd1; tick(); chk("coll_rd1", 32'(valor), 32'h20);

    // Read-before-write at address 1
    start();
    put(8'hA1); put(8'hB2);
    start();
    put(8'h00);
    dir_lect = 2'd1;
    tick();
    chk("rbw_before", 32'(valor), 32'h B2);
    put(8'h3C);
    chk("rbw_old", 32'(valor), 32'h B2);
    tick();
    chk("rbw_new", 32'(valor), 32'h 3C);

    // Reset mid-capture
    start();
    put(8'h11); put(8'h22);
    rst = 1'b1;
    tick();
    chk("mrst_conteo", 32'(conteo), 0);
    chk("mrst_lleno", 32'(lleno), 0);
    chk("mrst_listo", 32'(listo_out), 0);
    chk("mrst_valor", 32'(valor), 0);
    rst = 1'b0;
    dir_lect = 2'd0; tick(); chk("mrst_rd0", 32'(valor), 32'h11);
    dir_lect = 2'd1; tick(); chk("mrst_rd1", 32'(valor), 32'h22);
    valido_in = 1'b1; dato_in = 8'hEE; tick(); valido_in = 1'b0;
    chk("mrst_idle_conteo", 32'(conteo), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
